vending_customer: RTL and testbench
===================================

Name: vending_customer

Overview:
- Customer-side counterpart of the vending machine: holds a purse of nickels, dimes and quarters.
- On a buy request it drives coins onto the machine's deposit input while the machine's enable is high.
- It collects change and refund coins back into the purse and reports whether a beverage was delivered or the payment was refunded.
- Sits in the verification environment opposite the vending block and replaces the nondeterministic coin source for directed and closed-loop tests.

Parameters:
- BITS, 4, width of each purse coin counter; counters saturate at 2^BITS-1.
- INIT5, 4, nickels in purse after reset.
- INIT10, 3, dimes in purse after reset.
- INIT25, 1, quarters in purse after reset.

Ports:
- clock  input  1  single clock, posedge.
- reset  input  1  asynchronous, active-high; clears/initialises all state immediately.
- buy  input  1  purchase request, sampled in IDLE only.
- enable  input  1  machine accepts coins (from vending enable).
- change  input  2  coin returned by machine; encoding NONE=0, NICKEL=1, DIME=2, QUARTER=3.
- beverage  input  1  machine releasing item.
- deposit  output  2  coin offered to machine, registered, same encoding.
- busy  output  1  state != IDLE.
- vend_ok  output  1  one-cycle pulse: beverage received.
- refunded  output  1  one-cycle pulse: transaction ended without beverage.
- rejected  output  1  one-cycle pulse: buy ignored, purse value < 25c.
- p5, p10, p25  output  BITS each  current purse contents.
- bev_count  output  BITS  beverages received since reset, saturating.

Behaviour:
- Values in nickel units: NICKEL=1, DIME=2, QUARTER=5. purse_value = p5 + 2*p10 + 5*p25, computed in BITS+4 bits with no overflow.
- Reset values:
  - deposit=NONE, state=IDLE, paid=0.
  - All pulses 0.
  - p5/p10/p25 = INIT5/INIT10/INIT25; bev_count=0.
- Internal paid: 4-bit count of nickel units tendered in the current transaction.
- States: IDLE, PAY, WAIT.
- IDLE:
  - deposit=NONE.
  - buy=1 and purse_value>=5: go PAY, paid:=0.
  - buy=1 and purse_value<5: rejected=1 for one cycle, stay IDLE.
- PAY, coin choice per edge. If enable=1 and paid<5, pick:
  - QUARTER if p25>0 and paid==0;
  - else DIME if p10>0;
  - else NICKEL if p5>0;
  - else QUARTER if p25>0.
- PAY, effect of a pick: deposit:=coin, decrement that purse counter, paid:=paid+value.
- PAY, no pick (enable=0, or paid>=5, or no coin chosen): deposit:=NONE.
- PAY exit: when paid>=5 at the edge, go WAIT with deposit:=NONE. Exactly one coin beyond the 25c threshold may have been sent; the machine returns any overpay as change.
- Deposit is registered, so the machine sees a coin one cycle after it is chosen. enable is still 1 on the following edge because the machine's total has not yet updated. paid, not enable, therefore stops overpayment.
- Change in PAY is a rejected coin (machine counter full):
  - increment purse counter (saturating);
  - paid:=paid-value, floored at 0;
  - the rejected coin may be retried on a later edge.
- Change in WAIT or IDLE: increment the matching purse counter, saturating at 2^BITS-1.
- Change and beverage may be high in the same cycle; both are processed.
- WAIT exits:
  - beverage=1: vend_ok=1, bev_count+1 (saturating), go IDLE.
  - enable=1 and beverage=0: machine has returned to ACCEPTING without vending; refunded=1, go IDLE.
  - beverage has priority over enable in the same cycle.
- buy asserted while busy is ignored, with no queueing.
- Reset mid-transaction restores INIT purse contents. Coins already sent are lost from the purse view; this is intended.
- Liveness is not guaranteed if the machine keeps rejecting the only available coins; the block keeps retrying.

Test Plan:
- Reset with INIT 4/3/1, buy=1, enable=1 -> deposit QUARTER next cycle; p25=0; WAIT; beverage pulse -> vend_ok=1, bev_count=1, purse 4/3/0.
- Purse 0/3/0, buy -> deposits DIME, DIME, DIME (30c); machine returns refund DIME x3, enable=1 -> refunded=1, purse 0/3/0.
- Purse 2/0/0, buy -> rejected=1 for one cycle, busy stays 0, deposit stays NONE.
- Purse 1/3/0 with machine nickel-only change available: DIME, DIME, DIME paid (6) -> change NICKEL coincident with beverage -> vend_ok=1, purse 2/0/0.
- PAY with machine returning the quarter as change (counter full) -> p25 restored to 1, paid back to 0, next pick DIME.
- Assert reset during WAIT with change=DIME -> immediately state IDLE, deposit NONE, purse 4/3/1, no pulses.

Source files
------------

// File: rtl/vending_customer.sv
// vending_customer: customer-side model of a vending machine user.
// Holds a purse of nickels, dimes and quarters. On a buy request it tenders
// coins onto the machine's deposit input until at least 25c has been paid.
// Returned coins go back into the purse, and a one-cycle pulse reports
// whether the transaction ended in a vend or a refund.
module vending_customer #(
  parameter int BITS   = 4,
  parameter int INIT5  = 4,
  parameter int INIT10 = 3,
  parameter int INIT25 = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            buy,
  input  logic            enable,
  input  logic [1:0]      change,
  input  logic            beverage,
  output logic [1:0]      deposit,
  output logic            busy,
  output logic            vend_ok,
  output logic            refunded,
  output logic            rejected,
  output logic [BITS-1:0] p5,
  output logic [BITS-1:0] p10,
  output logic [BITS-1:0] p25,
  output logic [BITS-1:0] bev_count
);

  typedef enum logic [1:0] {IDLE, PAY, WAIT} state_t;
  typedef enum logic [1:0] {
    COIN_NONE    = 2'd0,
    COIN_NICKEL  = 2'd1,
    COIN_DIME    = 2'd2,
    COIN_QUARTER = 2'd3
  } coin_t;

  state_t          state, state_n;
  coin_t           dep_q, dep_n, pick;
  logic [3:0]      paid, paid_n, paid_eff, cval, pval;
  logic [BITS+3:0] purse_value;
  logic            vend_n, ref_n, rej_n;
  logic [BITS-1:0] bev_n, p5_n, p10_n, p25_n;
  logic            inc5, inc10, inc25;

  // Counter update: +1 saturating on a returned coin, -1 on a tendered coin.
  function automatic logic [BITS-1:0] upd(input logic [BITS-1:0] p,
                                          input logic inc, input logic dec);
    logic [BITS-1:0] r;
    r = p;
    if (inc && !dec && p != '1) r = p + 1'b1;
    else if (dec && !inc)       r = p - 1'b1;
    return r;
  endfunction

  // Nickel-unit value of a coin code.
  function automatic logic [3:0] coin_val(input logic [1:0] c);
    logic [3:0] v;
    case (c)
      2'd1:    v = 4'd1;
      2'd2:    v = 4'd2;
      2'd3:    v = 4'd5;
      default: v = 4'd0;
    endcase
    return v;
  endfunction

  assign deposit = dep_q;
  assign busy    = (state != IDLE);

  // Purse value, change bookkeeping, coin choice and next-state logic.
  always_comb begin
    purse_value = (BITS+4)'(p5) + ((BITS+4)'(p10) << 1) + (BITS+4)'(p25) * (BITS+4)'(5);
    cval  = coin_val(change);
    inc5  = (change == COIN_NICKEL);
    inc10 = (change == COIN_DIME);
    inc25 = (change == COIN_QUARTER);
    // A coin coming back while paying was refused by the machine, so it no
    // longer counts towards the amount tendered.
    paid_eff = paid;
    if (state == PAY && change != COIN_NONE)
      paid_eff = (paid >= cval) ? paid - cval : 4'd0;

    state_n = state;
    paid_n  = paid;
    dep_n   = COIN_NONE;
    pick    = COIN_NONE;
    vend_n  = 1'b0;
    ref_n   = 1'b0;
    rej_n   = 1'b0;
    bev_n   = bev_count;

    case (state)
      IDLE: begin
        if (buy) begin
          if (purse_value >= (BITS+4)'(5)) begin
            state_n = PAY;
            paid_n  = 4'd0;
          end else begin
            rej_n = 1'b1;
          end
        end
      end
      PAY: begin
        paid_n = paid_eff;
        if (paid_eff >= 4'd5) begin
          state_n = WAIT;
        end else if (enable) begin
          // Choice uses the registered purse: a coin refused this edge is not
          // re-offered until the next one.
          if (p25 != '0 && paid_eff == 4'd0) pick = COIN_QUARTER;
          else if (p10 != '0)                pick = COIN_DIME;
          else if (p5 != '0)                 pick = COIN_NICKEL;
          else if (p25 != '0)                pick = COIN_QUARTER;
          dep_n  = pick;
          paid_n = paid_eff + coin_val(pick);
        end
      end
      WAIT: begin
        if (beverage) begin
          vend_n  = 1'b1;
          bev_n   = (bev_count == '1) ? bev_count : bev_count + 1'b1;
          state_n = IDLE;
        end else if (enable) begin
          ref_n   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    pval  = coin_val(pick);
    p5_n  = upd(p5,  inc5,  pick == COIN_NICKEL);
    p10_n = upd(p10, inc10, pick == COIN_DIME);
    p25_n = upd(p25, inc25, pick == COIN_QUARTER);
  end

  // State, purse and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      paid      <= '0;
      dep_q     <= COIN_NONE;
      vend_ok   <= 1'b0;
      refunded  <= 1'b0;
      rejected  <= 1'b0;
      p5        <= BITS'(INIT5);
      p10       <= BITS'(INIT10);
      p25       <= BITS'(INIT25);
      bev_count <= '0;
    end else begin
      state     <= state_n;
      paid      <= paid_n;
      dep_q     <= dep_n;
      vend_ok   <= vend_n;
      refunded  <= ref_n;
      rejected  <= rej_n;
      p5        <= p5_n;
      p10       <= p10_n;
      p25       <= p25_n;
      bev_count <= bev_n;
    end
  end

endmodule

// File: tb/tb_vending_customer.sv
// Directed bench for vending_customer: the bench plays the machine, an
// expected-deposit queue is filled when a purchase is started and drained as
// coins appear on deposit.
module tb_vending_customer;

  localparam logic [1:0] NONE = 2'd0;
  localparam logic [1:0] NIC  = 2'd1;
  localparam logic [1:0] DIM  = 2'd2;
  localparam logic [1:0] QTR  = 2'd3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       buy = 1'b0, enable = 1'b0, beverage = 1'b0;
  logic [1:0] change = NONE;
  logic [1:0] deposit;
  logic       busy, vend_ok, refunded, rejected;
  logic [3:0] p5, p10, p25, bev_count;

  logic [1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  vending_customer #(.BITS(4), .INIT5(4), .INIT10(3), .INIT25(1)) dut (
    .clock(clock), .reset(reset), .buy(buy), .enable(enable),
    .change(change), .beverage(beverage), .deposit(deposit), .busy(busy),
    .vend_ok(vend_ok), .refunded(refunded), .rejected(rejected),
    .p5(p5), .p10(p10), .p25(p25), .bev_count(bev_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Keeps enable high, pops each tendered coin against the queue, then takes
  // the exit edge into WAIT.
  task automatic run_pay();
    int unsigned n = 0;
    bit done = 0;
    logic [1:0] e;
    enable = 1'b1;
    while (!done && n < 20) begin
      tick();
      n++;
      if (deposit != NONE) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL deposit_extra got %0d want none", deposit);
          done = 1;
        end else begin
          e = exp_q.pop_front();
          if (deposit !== e) begin
            errors++;
            $display("FAIL deposit_seq got %0d want %0d", deposit, e);
          end
          if (exp_q.size() == 0) done = 1;
        end
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL pay_timeout got %0d coins left want 0", exp_q.size());
      exp_q.delete();
    end
    enable = 1'b0;
    tick();
    checks++;
    if ({busy, deposit} !== {1'b1, NONE}) begin
      errors++;
      $display("FAIL wait_entry got busy=%b dep=%0d want busy=1 dep=0", busy, deposit);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({deposit, busy, vend_ok, refunded, rejected} !== {NONE, 4'b0000}) begin
      errors++;
      $display("FAIL reset_outputs got dep=%0d busy=%b pulses=%b%b%b want 0", deposit, busy, vend_ok, refunded, rejected);
    end
    checks++;
    if ({p5, p10, p25, bev_count} !== {4'd4, 4'd3, 4'd1, 4'd0}) begin
      errors++;
      $display("FAIL reset_purse got %0d/%0d/%0d bev %0d want 4/3/1 bev 0", p5, p10, p25, bev_count);
    end
  endtask

  task automatic test_vend();
    exp_q.push_back(QTR);
    buy = 1'b1; enable = 1'b1;
    tick();
    buy = 1'b0;
    run_pay();
    checks++;
    if (p25 !== 4'd0) begin
      errors++; $display("FAIL vend_p25 got %0d want 0", p25);
    end
    beverage = 1'b1;
    tick();
    beverage = 1'b0;
    checks++;
    if ({vend_ok, refunded, busy, bev_count} !== {3'b100, 4'd1}) begin
      errors++;
      $display("FAIL vend_pulse got ok=%b ref=%b busy=%b bev=%0d want 1 0 0 1", vend_ok, refunded, busy, bev_count);
    end
    checks++;
    if ({p5, p10, p25} !== {4'd4, 4'd3, 4'd0}) begin
      errors++; $display("FAIL vend_purse got %0d/%0d/%0d want 4/3/0", p5, p10, p25);
    end
    tick();
    checks++;
    if (vend_ok !== 1'b0) begin
      errors++; $display("FAIL vend_one_cycle got %b want 0", vend_ok);
    end
  endtask

  task automatic test_refund();
    exp_q.push_back(DIM); exp_q.push_back(DIM); exp_q.push_back(DIM);
    buy = 1'b1;
    tick();
    buy = 1'b0;
    run_pay();
    change = DIM;
    repeat (3) tick();
    change = NONE;
    checks++;
    if ({busy, refunded, p10} !== {2'b10, 4'd3}) begin
      errors++; $display("FAIL refund_wait got busy=%b ref=%b p10=%0d want 1 0 3", busy, refunded, p10);
    end
    enable = 1'b1;
    tick();
    enable = 1'b0;
    checks++;
    if ({refunded, vend_ok, busy} !== 3'b100) begin
      errors++; $display("FAIL refund_pulse got ref=%b ok=%b busy=%b want 1 0 0", refunded, vend_ok, busy);
    end
    checks++;
    if ({p5, p10, p25, bev_count} !== {4'd4, 4'd3, 4'd0, 4'd1}) begin
      errors++; $display("FAIL refund_purse got %0d/%0d/%0d bev %0d want 4/3/0 bev 1", p5, p10, p25, bev_count);
    end
    tick();
    checks++;
    if (refunded !== 1'b0) begin
      errors++; $display("FAIL refund_one_cycle got %b want 0", refunded);
    end
  endtask

  task automatic test_busy_ignore();
    exp_q.push_back(DIM); exp_q.push_back(DIM); exp_q.push_back(DIM);
    buy = 1'b1;
    tick();
    run_pay();
    tick();
    checks++;
    if ({busy, vend_ok, rejected, deposit} !== {3'b100, NONE}) begin
      errors++; $display("FAIL busy_hold got busy=%b ok=%b rej=%b dep=%0d want 1 0 0 0", busy, vend_ok, rejected, deposit);
    end
    buy = 1'b0;
    beverage = 1'b1;
    tick();
    beverage = 1'b0;
    tick();
    checks++;
    if ({busy, deposit, bev_count, p5, p10, p25} !== {1'b0, NONE, 4'd2, 4'd4, 4'd0, 4'd0}) begin
      errors++; $display("FAIL busy_after got busy=%b dep=%0d bev=%0d purse %0d/%0d/%0d want 0 0 2 4/0/0", busy, deposit, bev_count, p5, p10, p25);
    end
  endtask

  task automatic test_reject();
    buy = 1'b1;
    tick();
    buy = 1'b0;
    checks++;
    if ({rejected, busy, deposit} !== {2'b10, NONE}) begin
      errors++; $display("FAIL reject_pulse got rej=%b busy=%b dep=%0d want 1 0 0", rejected, busy, deposit);
    end
    tick();
    checks++;
    if ({rejected, busy, deposit} !== {2'b00, NONE}) begin
      errors++; $display("FAIL reject_one_cycle got rej=%b busy=%b dep=%0d want 0 0 0", rejected, busy, deposit);
    end
  endtask

  task automatic test_nickel_change();
    change = NIC;
    tick();
    change = NONE;
    repeat (5) exp_q.push_back(NIC);
    buy = 1'b1;
    tick();
    buy = 1'b0;
    run_pay();
    checks++;
    if ({p5, p10, p25} !== {4'd0, 4'd0, 4'd0}) begin
      errors++; $display("FAIL nickel_spent got %0d/%0d/%0d want 0/0/0", p5, p10, p25);
    end
    beverage = 1'b1; change = NIC;
    tick();
    beverage = 1'b0; change = NONE;
    checks++;
    if ({vend_ok, busy, p5, bev_count} !== {2'b10, 4'd1, 4'd3}) begin
      errors++; $display("FAIL nickel_vend got ok=%b busy=%b p5=%0d bev=%0d want 1 0 1 3", vend_ok, busy, p5, bev_count);
    end
  endtask

  task automatic test_quarter_reject();
    logic [1:0] e;
    test_reset();
    exp_q.push_back(QTR); exp_q.push_back(DIM); exp_q.push_back(DIM); exp_q.push_back(DIM);
    buy = 1'b1; enable = 1'b1;
    tick();
    buy = 1'b0;
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({deposit, p25} !== {e, 4'd0}) begin
      errors++; $display("FAIL qrej_first got dep=%0d p25=%0d want %0d 0", deposit, p25, e);
    end
    change = QTR;
    tick();
    change = NONE;
    e = exp_q.pop_front();
    checks++;
    if ({deposit, busy, p5, p10, p25} !== {e, 1'b1, 4'd4, 4'd2, 4'd1}) begin
      errors++; $display("FAIL qrej_retry got dep=%0d busy=%b purse %0d/%0d/%0d want %0d 1 4/2/1", deposit, busy, p5, p10, p25, e);
    end
    run_pay();
    beverage = 1'b1;
    tick();
    beverage = 1'b0;
    checks++;
    if ({vend_ok, p5, p10, p25, bev_count} !== {1'b1, 4'd4, 4'd0, 4'd1, 4'd1}) begin
      errors++; $display("FAIL qrej_vend got ok=%b purse %0d/%0d/%0d bev %0d want 1 4/0/1 1", vend_ok, p5, p10, p25, bev_count);
    end
  endtask

  task automatic test_reset_wait();
    exp_q.push_back(QTR);
    buy = 1'b1;
    tick();
    buy = 1'b0;
    run_pay();
    change = DIM;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, deposit, vend_ok, refunded, rejected} !== {1'b0, NONE, 3'b000}) begin
      errors++; $display("FAIL rst_wait_out got busy=%b dep=%0d pulses=%b%b%b want 0", busy, deposit, vend_ok, refunded, rejected);
    end
    checks++;
    if ({p5, p10, p25, bev_count} !== {4'd4, 4'd3, 4'd1, 4'd0}) begin
      errors++; $display("FAIL rst_wait_purse got %0d/%0d/%0d bev %0d want 4/3/1 0", p5, p10, p25, bev_count);
    end
    change = NONE;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({busy, p5, p10, p25} !== {1'b0, 4'd4, 4'd3, 4'd1}) begin
      errors++; $display("FAIL rst_release got busy=%b purse %0d/%0d/%0d want 0 4/3/1", busy, p5, p10, p25);
    end
  endtask

  task automatic test_saturation();
    change = NIC;
    repeat (12) tick();
    change = NONE;
    checks++;
    if (p5 !== 4'd15) begin
      errors++; $display("FAIL sat_p5 got %0d want 15", p5);
    end
  endtask

  initial begin
    test_reset();
    test_vend();
    test_refund();
    test_busy_ignore();
    test_reject();
    test_nickel_change();
    test_quarter_reject();
    test_reset_wait();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
